// File: rtl/factor_quiz_ctrl.sv
// rtl/factor_quiz_ctrl.sv - factorization quiz game sequencer
// Steps the display STATE code, times each phase, generates questions and judges answers.
module factor_quiz_ctrl #(
  parameter int READY_CYC  = 50_000_000,
  parameter int SHOW_CYC   = 100_000_000,
  parameter int INPUT_CYC  = 250_000_000,
  parameter int RESULT_CYC = 50_000_000,
  parameter int NUM_Q      = 5
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       START,
  input  logic       ENTER,
  input  logic [3:0] DIN,
  output logic [3:0] STATE,
  output logic [3:0] QUE,
  output logic [3:0] SCORE,
  output logic [3:0] ROUND,
  output logic       DONE
);

  localparam int MAX_AB = (READY_CYC > SHOW_CYC) ? READY_CYC : SHOW_CYC;
  localparam int MAX_CD = (INPUT_CYC > RESULT_CYC) ? INPUT_CYC : RESULT_CYC;
  localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW     = ($clog2(MAX_C) > 0) ? $clog2(MAX_C) : 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0000,
    S_DONE     = 4'b0001,
    S_READY    = 4'b0010,
    S_QUESTION = 4'b0011,
    S_INPUT    = 4'b0100,
    S_CORRECT  = 4'b0111,
    S_WRONG    = 4'b1000
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      lfsr_q, lfsr_d;
  logic [3:0]      que_q, que_d;
  logic [3:0]      score_q, score_d;
  logic [3:0]      round_q, round_d;
  logic            done_q, done_d;
  logic            expired;
  logic            last_round;
  logic [3:0]      answer;

  assign expired    = (timer_q == '0);
  assign last_round = (({1'b0, round_q} + 5'd1) >= 5'(NUM_Q));

  // Smallest prime factor of the question digit.
  always_comb begin
    case (que_q)
      4'd3, 4'd9: answer = 4'd3;
      4'd5:       answer = 4'd5;
      4'd7:       answer = 4'd7;
      default:    answer = 4'd2;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      lfsr_q  <= 4'b1001;
      que_q   <= 4'd0;
      score_q <= 4'd0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      que_q   <= que_d;
      score_q <= score_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (START) state_d = S_READY;
      S_READY:    if (expired) state_d = S_QUESTION;
      S_QUESTION: if (expired) state_d = S_INPUT;
      // ENTER takes priority over a timeout landing in the same cycle.
      S_INPUT: begin
        if (ENTER) state_d = (DIN == answer) ? S_CORRECT : S_WRONG;
        else if (expired) state_d = S_WRONG;
      end
      S_CORRECT, S_WRONG: if (expired) state_d = last_round ? S_DONE : S_READY;
      S_DONE:     if (START) state_d = S_READY;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lfsr_d  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    timer_d = expired ? timer_q : timer_q - 1'b1;
    que_d   = que_q;
    score_d = score_q;
    round_d = round_q;
    done_d  = (state_d == S_DONE);

    if (state_d != state_q) begin
      case (state_d)
        S_READY:            timer_d = TW'(READY_CYC - 1);
        S_QUESTION:         timer_d = TW'(SHOW_CYC - 1);
        S_INPUT:            timer_d = TW'(INPUT_CYC - 1);
        S_CORRECT, S_WRONG: timer_d = TW'(RESULT_CYC - 1);
        default:            timer_d = '0;
      endcase
    end

    if (state_q == S_READY && state_d == S_QUESTION)
      que_d = {1'b0, lfsr_q[2:0]} + 4'd2;

    if ((state_q == S_IDLE || state_q == S_DONE) && state_d == S_READY) begin
      score_d = 4'd0;
      round_d = 4'd0;
    end

    if ((state_q == S_CORRECT || state_q == S_WRONG) && state_d != state_q) begin
      round_d = round_q + 4'd1;
      if (state_q == S_CORRECT) score_d = score_q + 4'd1;
    end
  end

  assign STATE = state_q;
  assign QUE   = que_q;
  assign SCORE = score_q;
  assign ROUND = round_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_factor_quiz_ctrl.sv
// tb/tb_factor_quiz_ctrl.sv - self-checking bench for factor_quiz_ctrl
// Table-driven rounds plus randomized rounds against a game/LFSR reference model.
module tb_factor_quiz_ctrl;

  localparam int READY_CYC  = 4;
  localparam int SHOW_CYC   = 4;
  localparam int INPUT_CYC  = 8;
  localparam int RESULT_CYC = 2;
  localparam int NUM_Q      = 3;

  localparam logic [3:0] S_IDLE     = 4'b0000;
  localparam logic [3:0] S_DONE     = 4'b0001;
  localparam logic [3:0] S_READY    = 4'b0010;
  localparam logic [3:0] S_QUESTION = 4'b0011;
  localparam logic [3:0] S_INPUT    = 4'b0100;
  localparam logic [3:0] S_CORRECT  = 4'b0111;
  localparam logic [3:0] S_WRONG    = 4'b1000;

  logic       CLK;
  logic       nRST;
  logic       START;
  logic       ENTER;
  logic [3:0] DIN;
  logic [3:0] STATE;
  logic [3:0] QUE;
  logic [3:0] SCORE;
  logic [3:0] ROUND;
  logic       DONE;

  factor_quiz_ctrl #(
    .READY_CYC (READY_CYC),
    .SHOW_CYC  (SHOW_CYC),
    .INPUT_CYC (INPUT_CYC),
    .RESULT_CYC(RESULT_CYC),
    .NUM_Q     (NUM_Q)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .START(START),
    .ENTER(ENTER),
    .DIN  (DIN),
    .STATE(STATE),
    .QUE  (QUE),
    .SCORE(SCORE),
    .ROUND(ROUND),
    .DONE (DONE)
  );

  typedef struct {
    logic       use_enter;
    int         enter_cyc;
    logic       correct;
    logic [3:0] wrong_din;
    logic       chg_din;
    logic       poke;
    logic [3:0] exp_state;
  } round_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         model_score;
  int         model_round;
  int         model_que = 0;
  int         m_lfsr = 0;
  int         lfsr_hist = 0;
  int         que_seen = 0;
  logic [3:0] prev_state = 4'd0;
  logic [3:0] ans_tab [16];
  logic [3:0] bad_tab [12];
  round_t     tbl [6];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  // Reference LFSR for x^4+x^3+1: double the value and feed in bit3 xor bit2.
  always @(posedge CLK) begin
    if (!nRST) m_lfsr <= 9;
    else m_lfsr <= ((m_lfsr * 2) % 16) + (((m_lfsr / 8) + (m_lfsr / 4)) % 2);
  end

  always @(negedge CLK) begin
    if (nRST && prev_state == S_READY && STATE == S_QUESTION) begin
      model_que = (lfsr_hist % 8) + 2;
      check("que_generated", QUE, model_que);
      check("que_range", (QUE >= 4'd2 && QUE <= 4'd9), 1);
      que_seen++;
    end
    prev_state = STATE;
    lfsr_hist  = m_lfsr;
  end

  task automatic play_round(input round_t r);
    logic [3:0] din_v;
    logic       entered;
    din_v   = 4'd0;
    entered = 1'b0;
    for (int i = 0; i < READY_CYC; i++) begin
      check("ready_state", STATE, S_READY);
      if (r.poke && i == 1) begin START = 1'b1; ENTER = 1'b1; end
      step();
      START = 1'b0; ENTER = 1'b0;
    end
    check("ready_score_kept", SCORE, model_score);
    check("ready_round_kept", ROUND, model_round);
    for (int i = 0; i < SHOW_CYC; i++) begin
      check("question_state", STATE, S_QUESTION);
      check("question_que_hold", QUE, model_que);
      if (r.poke && i == 1) begin START = 1'b1; ENTER = 1'b1; end
      step();
      START = 1'b0; ENTER = 1'b0;
    end
    for (int i = 0; i < INPUT_CYC && !entered; i++) begin
      check("input_state", STATE, S_INPUT);
      if (r.poke && i == 0) START = 1'b1;
      if (r.use_enter && i == r.enter_cyc - 1) begin
        din_v   = r.correct ? ans_tab[model_que] : r.wrong_din;
        DIN     = din_v;
        ENTER   = 1'b1;
        entered = 1'b1;
      end
      step();
      START = 1'b0; ENTER = 1'b0;
      if (entered && r.chg_din) DIN = ~din_v;
    end
    check("input_round_kept", ROUND, model_round);
    for (int i = 0; i < RESULT_CYC; i++) begin
      check("verdict_state", STATE, r.exp_state);
      check("verdict_que_hold", QUE, model_que);
      check("verdict_score_kept", SCORE, model_score);
      if (r.poke && i == 0) begin START = 1'b1; ENTER = 1'b1; DIN = ~DIN; end
      step();
      START = 1'b0; ENTER = 1'b0;
    end
    if (r.exp_state == S_CORRECT) model_score++;
    model_round++;
    check("round_end_score", SCORE, model_score);
    check("round_end_round", ROUND, model_round);
    if (model_round < NUM_Q) begin
      check("next_ready_state", STATE, S_READY);
      check("next_ready_done", DONE, 0);
    end else begin
      check("game_done_state", STATE, S_DONE);
      check("game_done_flag", DONE, 1);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
    model_score = 0;
    model_round = 0;
    check("start_state", STATE, S_READY);
    check("start_score_clear", SCORE, 0);
    check("start_round_clear", ROUND, 0);
    check("start_done_low", DONE, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    round_t r;
    ans_tab = '{default: 4'd0};
    ans_tab[2] = 4'd2; ans_tab[3] = 4'd3; ans_tab[4] = 4'd2; ans_tab[5] = 4'd5;
    ans_tab[6] = 4'd2; ans_tab[7] = 4'd7; ans_tab[8] = 4'd2; ans_tab[9] = 4'd3;
    bad_tab = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    //            enter  cyc correct wrong  chg   poke  expected verdict
    tbl[0] = '{1'b1, 3, 1'b1, 4'd0,  1'b0, 1'b1, S_CORRECT};
    tbl[1] = '{1'b1, 2, 1'b0, 4'd10, 1'b1, 1'b1, S_WRONG};
    tbl[2] = '{1'b1, 8, 1'b1, 4'd0,  1'b0, 1'b0, S_CORRECT};
    tbl[3] = '{1'b0, 1, 1'b1, 4'd0,  1'b0, 1'b1, S_WRONG};
    tbl[4] = '{1'b1, 1, 1'b0, 4'd0,  1'b1, 1'b0, S_WRONG};
    tbl[5] = '{1'b1, 1, 1'b1, 4'd0,  1'b1, 1'b1, S_CORRECT};

    nRST = 1'b0; START = 1'b0; ENTER = 1'b0; DIN = 4'd0;
    model_score = 0; model_round = 0;
    step(); step(); step();
    check("reset_state", STATE, S_IDLE);
    check("reset_que", QUE, 0);
    check("reset_score", SCORE, 0);
    check("reset_round", ROUND, 0);
    check("reset_done", DONE, 0);
    nRST = 1'b1;
    step();
    ENTER = 1'b1;
    step();
    ENTER = 1'b0;
    step();
    check("idle_ignores_enter", STATE, S_IDLE);
    check("idle_que_hold", QUE, 0);

    pulse_start();
    for (int k = 0; k < 3; k++) play_round(tbl[k]);
    check("game1_score", SCORE, 2);
    check("game1_round", ROUND, 3);
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 3) ENTER = 1'b1;
      step();
      ENTER = 1'b0;
      check("done_hold_state", STATE, S_DONE);
      check("done_hold_flag", DONE, 1);
    end
    check("done_que_hold", QUE, model_que);

    pulse_start();
    for (int k = 3; k < 6; k++) play_round(tbl[k]);
    check("game2_score", SCORE, 1);
    check("game2_round", ROUND, 3);

    pulse_start();
    for (int i = 0; i < READY_CYC + SHOW_CYC + 2; i++) step();
    check("midreset_in_input", STATE, S_INPUT);
    nRST = 1'b0;
    step();
    check("midreset_state", STATE, S_IDLE);
    check("midreset_que", QUE, 0);
    check("midreset_score", SCORE, 0);
    check("midreset_round", ROUND, 0);
    check("midreset_done", DONE, 0);
    nRST = 1'b1;
    step();
    check("midreset_idle_after", STATE, S_IDLE);

    pulse_start();
    for (int n = 0; n < 50; n++) begin
      r.use_enter = ($urandom_range(0, 3) != 0);
      r.enter_cyc = $urandom_range(1, INPUT_CYC);
      r.correct   = 1'($urandom_range(0, 1));
      r.wrong_din = bad_tab[$urandom_range(0, 11)];
      r.chg_din   = 1'($urandom_range(0, 1));
      r.poke      = 1'($urandom_range(0, 1));
      r.exp_state = (r.use_enter && r.correct) ? S_CORRECT : S_WRONG;
      play_round(r);
      if (model_round == NUM_Q) pulse_start();
    end
    check("que_entries_seen", (que_seen >= 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
